// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit instruction format.
// The encoder/loader and the fetch/decode side both use these, so the field layout lives in one place.
package isa_pkg;

    localparam int OPCODE_W = 4;
    localparam int REG_W    = 4;
    localparam int IMM_W    = 8;
    localparam int INSTR_W  = OPCODE_W + REG_W + IMM_W;

    // Field bit positions inside an instruction word
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int REG_MSB    = 11;
    localparam int REG_LSB    = 8;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    // Named opcodes shared with the decoder
    localparam logic [OPCODE_W-1:0] OP_LOSC  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUPIX = 4'b1100;

    // Pack a field triple into one instruction word; every opcode value is legal
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [OPCODE_W-1:0] opcode,
        input logic [REG_W-1:0]    reg_f,
        input logic [IMM_W-1:0]    imm
    );
        logic [INSTR_W-1:0] word;
        word                         = {INSTR_W{1'b0}};
        word[OPCODE_MSB:OPCODE_LSB]  = opcode;
        word[REG_MSB:REG_LSB]        = reg_f;
        word[IMM_MSB:IMM_LSB]        = imm;
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Small synchronous FIFO buffering packed instruction words between the
// field producer and the instruction memory write port.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    // Guard against overflow/underflow even if the caller misbehaves
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign rdata = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Word storage; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        end
    end

    // Read/write pointers; reset discards any buffered words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs {opcode, reg, imm} triples into 16-bit
// words, buffers them, and streams them into instruction memory starting at
// base_addr. A load FSM counts accepted and written words and pulses done.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int N          = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_reg,
    input  logic [7:0]        in_imm,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              addr_wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } load_state_t;

    load_state_t       state_r;
    load_state_t       state_next_s;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   accepted_r;
    logic [ADDR_W:0]   written_r;
    logic [ADDR_W:0]   accepted_inc_s;
    logic [ADDR_W:0]   written_inc_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              addr_wrap_r;
    logic              start_ok_s;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic              active_s;
    logic [N-1:0]      packed_s;
    logic [N-1:0]      head_s;

    assign start_ok_s     = (state_r == IDLE) && start;
    assign active_s       = (state_r == LOAD) || (state_r == DRAIN);
    assign in_ready       = (state_r == LOAD) && !full_s && (accepted_r < len_r);
    assign push_s         = in_valid && in_ready;
    assign mem_we         = !empty_s && active_s;
    assign pop_s          = mem_we && mem_ready;
    assign accepted_inc_s = accepted_r + {{ADDR_W{1'b0}}, push_s};
    assign written_inc_s  = written_r + {{ADDR_W{1'b0}}, pop_s};
    assign packed_s       = pack_instr(in_opcode, in_reg, in_imm);

    // Words leave only from registered FIFO storage; zero when not strobing
    assign mem_wdata = mem_we ? head_s : {N{1'b0}};
    assign mem_addr  = mem_addr_r;
    assign addr_wrap = addr_wrap_r;
    assign busy      = active_s;
    assign done      = (state_r == DONE);

    sync_fifo #(
        .WIDTH (N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (packed_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Load FSM next state; completion looks at this cycle's push/pop so done follows the last write directly
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (length == {(ADDR_W+1){1'b0}}) ? DONE : LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (accepted_inc_s == len_r) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = LOAD;
                end
            end
            DRAIN: begin
                if (written_inc_s == len_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters, write address and wrap flag; a new start re-arms all of them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            len_r       <= {(ADDR_W+1){1'b0}};
            accepted_r  <= {(ADDR_W+1){1'b0}};
            written_r   <= {(ADDR_W+1){1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            addr_wrap_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (start_ok_s) begin
                len_r       <= length;
                accepted_r  <= {(ADDR_W+1){1'b0}};
                written_r   <= {(ADDR_W+1){1'b0}};
                mem_addr_r  <= base_addr;
                addr_wrap_r <= 1'b0;
            end else begin
                accepted_r <= accepted_inc_s;
                written_r  <= written_inc_s;
                if (pop_s) begin
                    mem_addr_r <= mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (mem_addr_r == {ADDR_W{1'b1}}) begin
                        addr_wrap_r <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a table of field triples with
// hand-packed words drives several loads; a posedge logger records every
// memory write, which is then compared against the table.
module tb_instr_encoder_loader;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rg;
        logic [7:0]  imm;
        logic [15:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_reg;
    logic [7:0]  in_imm;
    logic        mem_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        addr_wrap;

    vec_t        tab [8];
    logic [7:0]  wa_q [$];
    logic [15:0] wd_q [$];
    int          wc_q [$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          both_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          we_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          k_idx;
    int          k_end;
    int          log_base;
    int          acc0;
    int          both0;
    int          wrap_hist [16];

    instr_encoder_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_reg    (in_reg),
        .in_imm    (in_imm),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .addr_wrap (addr_wrap)
    );

    always #5 clk = ~clk;

    // Record completed writes, accepts, simultaneous push/pop and done pulses
    always @(posedge clk) begin
        if (mem_we && mem_ready) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
        if (in_valid && in_ready && mem_we && mem_ready) both_cnt <= both_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present the next table triple; advance when the DUT will accept it at the coming edge
    task automatic drive_feed();
        if (k_idx < k_end) begin
            in_valid  = 1'b1;
            in_opcode = tab[k_idx].op;
            in_reg    = tab[k_idx].rg;
            in_imm    = tab[k_idx].imm;
            if (in_ready) k_idx++;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    // Start a load of len table entries from index first; mem_ready held low for the first stall cycles
    task automatic run_load(input logic [7:0] base, input logic [8:0] len, input int first, input int stall);
        int   t;
        int   d0;
        int   n;
        logic fin;
        d0       = done_cnt;
        log_base = wa_q.size();
        acc0     = acc_cnt;
        both0    = both_cnt;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        in_valid  = 1'b0;
        mem_ready = (stall == 0);
        k_idx     = first;
        k_end     = first + int'(len);
        for (int i = 0; i < 16; i++) wrap_hist[i] = 0;
        fin = 1'b0;
        t   = 0;
        while (!fin && t < 300) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            n = wa_q.size() - log_base;
            if (n < 16) wrap_hist[n] = int'(addr_wrap);
            if (stall > 0 && t == stall - 2) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_accepts", 32'(acc_cnt - acc0), 32'd4);
                chk("stall_mem_we", 32'(mem_we), 32'd1);
                chk("stall_addr", 32'(mem_addr), 32'(base));
                chk("stall_wdata", 32'(mem_wdata), 32'(tab[first].word));
            end
            if (stall > 0 && t == stall - 1) begin
                chk("stall_addr_held", 32'(mem_addr), 32'(base));
                chk("stall_wdata_held", 32'(mem_wdata), 32'(tab[first].word));
            end
            drive_feed();
            mem_ready = (t >= stall);
            if (done_cnt != d0) fin = 1'b1;
        end
        chk("load_finished", 32'(fin), 32'd1);
        @(negedge clk);
        chk("done_single_pulse", 32'(done_cnt - d0), 32'd1);
        chk("done_low_after", 32'(done), 32'd0);
        chk("busy_low_after", 32'(busy), 32'd0);
    endtask

    // Compare the writes of the last load against the table
    task automatic check_writes(input logic [7:0] base, input int len, input int first);
        logic [7:0] ea;
        chk("write_count", 32'(wa_q.size() - log_base), 32'(len));
        for (int i = 0; i < len; i++) begin
            if (log_base + i < wa_q.size()) begin
                ea = base + 8'(i);
                chk("write_addr", 32'(wa_q[log_base + i]), 32'(ea));
                chk("write_data", 32'(wd_q[log_base + i]), 32'(tab[first + i].word));
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_addr_wrap"}, 32'(addr_wrap), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int t;
        int d0;
        int we0;

        tab[0] = '{4'h0, 4'h3, 8'h5A, 16'h035A};
        tab[1] = '{4'hC, 4'h1, 8'hFF, 16'hC1FF};
        tab[2] = '{4'h7, 4'hF, 8'h00, 16'h7F00};
        tab[3] = '{4'hF, 4'hF, 8'hFF, 16'hFFFF};
        tab[4] = '{4'h0, 4'h0, 8'h00, 16'h0000};
        tab[5] = '{4'h1, 4'h2, 8'h34, 16'h1234};
        tab[6] = '{4'hA, 4'h5, 8'hC3, 16'hA5C3};
        tab[7] = '{4'h8, 4'h0, 8'h01, 16'h8001};

        rst       = 1'b0;
        start     = 1'b0;
        base_addr = 8'h00;
        length    = 9'd0;
        in_valid  = 1'b0;
        in_opcode = 4'h0;
        in_reg    = 4'h0;
        in_imm    = 8'h00;
        mem_ready = 1'b1;
        k_idx     = 0;
        k_end     = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b1;

        // Spec example: three words at 0x10, done one cycle after the last write
        run_load(8'h10, 9'd3, 0, 0);
        check_writes(8'h10, 3, 0);
        chk("done_latency", 32'(done_cyc - wc_q[wc_q.size() - 1]), 32'd1);

        // Whole table, free-running memory
        run_load(8'h20, 9'd8, 0, 0);
        check_writes(8'h20, 8, 0);

        // Memory stalled 10 cycles: FIFO fills to 4, outputs held, then push and pop overlap
        run_load(8'h40, 9'd8, 0, 10);
        check_writes(8'h40, 8, 0);
        chk("push_pop_overlap", 32'(both_cnt - both0), 32'd4);

        // Address wrap FE,FF,00,01
        run_load(8'hFE, 9'd4, 3, 0);
        check_writes(8'hFE, 4, 3);
        chk("wrap_after_1st", 32'(wrap_hist[1]), 32'd0);
        chk("wrap_after_3rd", 32'(wrap_hist[3]), 32'd1);
        chk("wrap_sticky", 32'(addr_wrap), 32'd1);

        // Zero length: done pulse right after start, no writes, wrap flag cleared
        d0  = done_cnt;
        we0 = we_cnt;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'h55;
        length    = 9'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_wrap_cleared", 32'(addr_wrap), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("len0_done_low", 32'(done), 32'd0);
        @(negedge clk);
        chk("len0_no_we", 32'(we_cnt - we0), 32'd0);
        chk("len0_one_pulse", 32'(done_cnt - d0), 32'd1);

        // Async reset after 2 of 5 writes, then restart at base 0
        @(negedge clk);
        log_base  = wa_q.size();
        start     = 1'b1;
        base_addr = 8'h80;
        length    = 9'd5;
        mem_ready = 1'b1;
        k_idx     = 3;
        k_end     = 8;
        t         = 0;
        while ((wa_q.size() - log_base) < 2 && t < 50) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            drive_feed();
        end
        chk("midload_two_writes", 32'(wa_q.size() - log_base), 32'd2);
        chk("midload_busy", 32'(busy), 32'd1);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        run_load(8'h00, 9'd2, 5, 0);
        check_writes(8'h00, 2, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
